operand_stack: RTL and testbench

Parametrised operand stack for the bytecode execution core, superseding the single-push/pop stack. One synchronous block RAM holds the stack contents. A command FSM executes PUSH, POP, PEEK, DUP and SWAP with fixed latencies. It exposes occupancy, full/empty flags and an error pulse on overflow, underflow and illegal opcodes, so the decode/control unit can raise JVM stack exceptions instead of silently corrupting state.

---
 rtl/operand_stack_pkg.sv | 26 ++
 rtl/operand_stack_if.sv | 31 +++
 rtl/operand_stack_block_ram.sv | 19 +
 rtl/operand_stack.sv | 164 ++++++++++++++++
 tb/tb_operand_stack.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_stack_pkg.sv
// Shared types for the bytecode operand stack.
// Command codes and the command FSM state encoding.
package stack_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    PEEK = 3'd3,
    DUP  = 3'd4,
    SWAP = 3'd5
  } stack_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP,
    WR_A,
    WR_B,
    FIN
  } stack_state_t;

  localparam int OP_WIDTH = 3;

endpackage

// File: rtl/operand_stack_if.sv
// Command/result bundle between control unit and operand stack.
// master drives commands, slave (the stack) returns results.
interface operand_stack_if
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  trigger;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] write_value;
  logic [DATA_WIDTH-1:0] read_value;
  logic                  done;
  logic                  error;
  logic                  busy;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;

  modport master (
    output trigger, op, write_value,
    input  read_value, done, error, busy,
    input  count, empty, full
  );

  modport slave (
    input  trigger, op, write_value,
    output read_value, done, error, busy,
    output count, empty, full
  );
endinterface

// File: rtl/operand_stack_block_ram.sv
// Single-port synchronous RAM, one-cycle read latency.
// Contents are never reset.
module block_ram #(
  parameter int DATA = 32,
  parameter int SIZE = 1024
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(SIZE)-1:0] addr,
  input  logic [DATA-1:0]         wdata,
  output logic [DATA-1:0]         rdata
);
  logic [DATA-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/operand_stack.sv
// Operand stack: block RAM plus a fixed-latency command FSM.
// count is the stack pointer; top of stack sits at count-1.
module operand_stack
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 65536,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  operand_stack_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] TWO =
    (ADDR_WIDTH+1)'(2);

  stack_state_t state, state_nx;
  stack_op_t    op_in, op_q;
  logic         rej_q, reject;
  logic         done, error;
  logic         is_empty, is_full;

  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] read_value, temp;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [ADDR_WIDTH-1:0] cnt_a, top_a, nxt_a;

  assign op_in    = stack_op_t'(bus.op);
  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  assign cnt_a    = count[ADDR_WIDTH-1:0];
  assign top_a    = cnt_a - 1'b1;
  assign nxt_a    = top_a - 1'b1;

  always_comb begin
    reject = 1'b0;
    unique case (1'b1)
      (bus.op[2] && bus.op[1]): reject = 1'b1;
      (op_in == PUSH):          reject = is_full;
      (op_in == POP),
      (op_in == PEEK):          reject = is_empty;
      (op_in == DUP):           reject = is_full || is_empty;
      (op_in == SWAP):          reject = (count < TWO);
      default:                  reject = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.trigger) begin
          if (reject || op_in == NOP || op_in == PUSH)
            state_nx = FIN;
          else
            state_nx = RD_A;
        end
      RD_A:
        unique case (1'b1)
          (op_q == SWAP): state_nx = RD_B;
          (op_q == DUP):  state_nx = WR_A;
          default:        state_nx = FIN;
        endcase
      RD_B:    state_nx = CAP;
      CAP:     state_nx = WR_B;
      WR_A:    state_nx = FIN;
      WR_B:    state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Clearing ram_we on reset drops any write that was set up but not clocked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= NOP;
      rej_q      <= 1'b0;
      count      <= '0;
      read_value <= '0;
      temp       <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      ram_we <= 1'b0;
      unique case (state)
        IDLE:
          if (bus.trigger) begin
            op_q  <= op_in;
            rej_q <= reject;
            if (!reject) begin
              ram_we    <= (op_in == PUSH);
              ram_addr  <= (op_in == PUSH) ? cnt_a : top_a;
              ram_wdata <= bus.write_value;
            end
          end
        RD_A:
          if (op_q == SWAP) ram_addr <= nxt_a;
        RD_B: temp <= ram_rdata;
        CAP: begin
          ram_we    <= 1'b1;
          ram_addr  <= top_a;
          ram_wdata <= ram_rdata;
        end
        WR_A: begin
          ram_we    <= 1'b1;
          ram_addr  <= cnt_a;
          ram_wdata <= ram_rdata;
        end
        WR_B: begin
          ram_we    <= 1'b1;
          ram_addr  <= nxt_a;
          ram_wdata <= temp;
        end
        FIN: begin
          done  <= 1'b1;
          error <= rej_q;
          if (!rej_q) begin
            if (op_q == PUSH || op_q == DUP)
              count <= count + 1'b1;
            if (op_q == POP)
              count <= count - 1'b1;
            if (op_q == POP || op_q == PEEK)
              read_value <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  block_ram #(
    .DATA (DATA_WIDTH),
    .SIZE (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.read_value = read_value;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.busy       = (state != IDLE);
  assign bus.count      = count;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack at DEPTH=4: directed table,
// multi-cycle corner sequences and a queue-model random run.
module tb_operand_stack;
  import stack_pkg::*;

  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int AW  = 2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] val;
    logic        err;
    int          lat;
    int          cnt;
    logic [31:0] rv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vec_t        tbl[$];
  logic [31:0] q[$];
  logic [31:0] model_rv;

  operand_stack_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  operand_stack #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] val,
                              input logic err, input int lat, input int cnt,
                              input logic [31:0] rv);
    vec_t v;
    v.op = op; v.val = val; v.err = err;
    v.lat = lat; v.cnt = cnt; v.rv = rv;
    return v;
  endfunction

  task automatic pulse_trig(input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    bus.trigger = 1'b1; bus.op = op; bus.write_value = val;
    @(posedge clk); #1;
    bus.trigger = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [31:0] val, input logic exp_err,
                         input int exp_lat, input int exp_cnt,
                         input logic [31:0] exp_rv);
    int lat;
    lat = 0;
    pulse_trig(op, val);
    chk({tag, " busy"}, bus.busy, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " error"}, bus.error, exp_err);
    chk({tag, " count"}, bus.count, exp_cnt);
    chk({tag, " read_value"}, bus.read_value, exp_rv);
    chk({tag, " empty"}, bus.empty, exp_cnt == 0);
    chk({tag, " full"}, bus.full, exp_cnt == DEP);
    chk({tag, " busy_done"}, bus.busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int ndone, at, n, lat;
    logic err;
    logic [2:0] op;
    logic [31:0] val, t;

    bus.trigger = 1'b0; bus.op = '0; bus.write_value = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst count", bus.count, 0);
    chk("rst empty", bus.empty, 1'b1);
    chk("rst full", bus.full, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst error", bus.error, 1'b0);
    chk("rst read_value", bus.read_value, 32'h0);
    @(negedge clk) rst = 1'b0;

    tbl.push_back(mk(PUSH, 32'hA, 0, 1, 1, 32'h0));
    tbl.push_back(mk(PUSH, 32'hB, 0, 1, 2, 32'h0));
    tbl.push_back(mk(PUSH, 32'hC, 0, 1, 3, 32'h0));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 2, 32'hC));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 1, 32'hB));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 0, 32'hA));
    tbl.push_back(mk(POP,  32'h0, 1, 1, 0, 32'hA));
    tbl.push_back(mk(PEEK, 32'h0, 1, 1, 0, 32'hA));
    tbl.push_back(mk(DUP,  32'h0, 1, 1, 0, 32'hA));
    tbl.push_back(mk(SWAP, 32'h0, 1, 1, 0, 32'hA));
    tbl.push_back(mk(PUSH, 32'h1, 0, 1, 1, 32'hA));
    tbl.push_back(mk(SWAP, 32'h0, 1, 1, 1, 32'hA));
    tbl.push_back(mk(PUSH, 32'h2, 0, 1, 2, 32'hA));
    tbl.push_back(mk(PUSH, 32'h3, 0, 1, 3, 32'hA));
    tbl.push_back(mk(PUSH, 32'h4, 0, 1, 4, 32'hA));
    tbl.push_back(mk(PUSH, 32'h5, 1, 1, 4, 32'hA));
    tbl.push_back(mk(DUP,  32'h0, 1, 1, 4, 32'hA));
    tbl.push_back(mk(3'd6, 32'h0, 1, 1, 4, 32'hA));
    tbl.push_back(mk(3'd7, 32'h0, 1, 1, 4, 32'hA));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 3, 32'h4));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 2, 32'h3));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 1, 32'h2));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 0, 32'h1));
    tbl.push_back(mk(PUSH, 32'h11, 0, 1, 1, 32'h1));
    tbl.push_back(mk(PUSH, 32'h22, 0, 1, 2, 32'h1));
    tbl.push_back(mk(SWAP, 32'h0, 0, 5, 2, 32'h1));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 1, 32'h11));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 0, 32'h22));
    tbl.push_back(mk(PUSH, 32'h7, 0, 1, 1, 32'h22));
    tbl.push_back(mk(DUP,  32'h0, 0, 3, 2, 32'h22));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 1, 32'h7));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 0, 32'h7));
    tbl.push_back(mk(NOP,  32'h0, 0, 1, 0, 32'h7));
    tbl.push_back(mk(PUSH, 32'h9, 0, 1, 1, 32'h7));
    tbl.push_back(mk(PEEK, 32'h0, 0, 2, 1, 32'h9));
    tbl.push_back(mk(POP,  32'h0, 0, 2, 0, 32'h9));

    foreach (tbl[i])
      run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].val,
              tbl[i].err, tbl[i].lat, tbl[i].cnt, tbl[i].rv);

    // Triggers during SWAP's busy window must be dropped
    run_cmd("bw push1", PUSH, 32'h11, 0, 1, 1, 32'h9);
    run_cmd("bw push2", PUSH, 32'h22, 0, 1, 2, 32'h9);
    pulse_trig(SWAP, 32'h0);
    pulse_trig(POP, 32'h0);
    pulse_trig(PUSH, 32'hDEAD);
    ndone = 0; at = 0;
    for (int i = 3; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        at = i;
      end
    end
    chk("bw ndone", ndone, 1);
    chk("bw done_at", at, 5);
    chk("bw count", bus.count, 2);
    run_cmd("bw pop1", POP, 32'h0, 0, 2, 1, 32'h11);
    run_cmd("bw pop2", POP, 32'h0, 0, 2, 0, 32'h22);

    // A trigger in the done cycle is accepted
    pulse_trig(PUSH, 32'h33);
    @(posedge clk); #1;
    chk("dc done1", bus.done, 1'b1);
    bus.trigger = 1'b1; bus.op = PUSH; bus.write_value = 32'h44;
    @(posedge clk); #1;
    bus.trigger = 1'b0;
    chk("dc gap", bus.done, 1'b0);
    @(posedge clk); #1;
    chk("dc done2", bus.done, 1'b1);
    chk("dc count", bus.count, 2);
    run_cmd("dc pop1", POP, 32'h0, 0, 2, 1, 32'h44);
    run_cmd("dc pop2", POP, 32'h0, 0, 2, 0, 32'h33);

    // Reset at k+3 of a SWAP
    run_cmd("rs push1", PUSH, 32'hAA, 0, 1, 1, 32'h33);
    run_cmd("rs push2", PUSH, 32'hBB, 0, 1, 2, 32'h33);
    pulse_trig(SWAP, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rs count", bus.count, 0);
    chk("rs empty", bus.empty, 1'b1);
    chk("rs busy", bus.busy, 1'b0);
    chk("rs done", bus.done, 1'b0);
    chk("rs error", bus.error, 1'b0);
    chk("rs read_value", bus.read_value, 32'h0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("rs no_done", ndone, 0);
    run_cmd("rs push", PUSH, 32'h55, 0, 1, 1, 32'h0);
    run_cmd("rs pop", POP, 32'h0, 0, 2, 0, 32'h55);

    // Random commands against a queue model
    q.delete();
    model_rv = 32'h55;
    for (int i = 0; i < 200; i++) begin
      op  = 3'($urandom_range(0, 7));
      val = $urandom;
      n   = q.size();
      err = 1'b0;
      lat = 1;
      case (op)
        3'd0: ;
        3'd1: if (n == DEP) err = 1'b1; else q.push_back(val);
        3'd2: if (n == 0) err = 1'b1;
              else begin model_rv = q.pop_back(); lat = 2; end
        3'd3: if (n == 0) err = 1'b1;
              else begin model_rv = q[n-1]; lat = 2; end
        3'd4: if (n == 0 || n == DEP) err = 1'b1;
              else begin q.push_back(q[n-1]); lat = 3; end
        3'd5: if (n < 2) err = 1'b1;
              else begin
                t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; lat = 5;
              end
        default: err = 1'b1;
      endcase
      run_cmd($sformatf("rnd%0d op%0d", i, op), op, val, err, lat,
              q.size(), model_rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
